// File: rtl/life_pkg.sv
// life_pkg: shared constants for the Game of Life cell-array stage
package life_pkg;
   localparam int BAND_ROWS = 4;
   typedef enum logic [1:0] {PH_IDLE, PH_WRITE_ARRAY, PH_RUN, PH_WRITE_MEM} phase_t;
   localparam logic [3:0] BIRTH_COUNT = 4'd3;
   localparam logic [3:0] SURVIVE_COUNT = 4'd2;
endpackage

// File: rtl/life_cell_next.sv
// life_cell_next: B3/S23 next-state of one cell from its eight neighbours
module life_cell_next import life_pkg::*; (
   input  logic [7:0] nbr,
   input  logic       cur,
   output logic       nxt
);
   logic [3:0] cnt;
   always_comb begin
      cnt = 4'($countones(nbr));
      nxt = (cnt == BIRTH_COUNT) | (cur & (cnt == SURVIVE_COUNT));
   end
endmodule

// File: rtl/life_grid.sv
// life_grid: toroidal Life grid with banded next-generation compute and atomic commit
module life_grid import life_pkg::*; #(
   parameter int COLS = 16,
   parameter int ROWS = 16,
   localparam int RW = $clog2(ROWS)
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      write_array,
   input  logic                      run,
   input  logic [1:0]                pos,
   input  logic                      write_mem,
   input  logic                      wr_req,
   input  logic [RW-1:0]             wr_row,
   input  logic [COLS-1:0]           wr_data,
   output logic                      wr_ack,
   input  logic [RW-1:0]             rd_row,
   output logic [COLS-1:0]           rd_data,
   output logic                      mem_we,
   output logic [1:0]                mem_addr,
   output logic [BAND_ROWS*COLS-1:0] mem_wdata,
   output logic [15:0]               generation,
   output logic                      gen_tick
);
   logic [ROWS-1:0][COLS-1:0]        grid, shadow;
   logic [BAND_ROWS+1:0][COLS-1:0]   win;
   logic [BAND_ROWS-1:0][COLS-1:0]   nxt;
   logic [3:0]                       band_done;
   logic [RW-1:0]                    base;
   phase_t                           phase;

   // window row i maps to grid row base+i-1, wrapping at the top and bottom edges
   function automatic logic [RW-1:0] win_row(input logic [1:0] p, input int i);
      int r;
      r = int'(p) * BAND_ROWS + i - 1;
      return (r < 0) ? RW'(ROWS - 1) : (r >= ROWS) ? '0 : RW'(r);
   endfunction

   always_comb begin
      phase = write_array ? PH_WRITE_ARRAY : run ? PH_RUN : write_mem ? PH_WRITE_MEM : PH_IDLE;
      base  = RW'(int'(pos) * BAND_ROWS);
      win   = '0;
      for (int i = 0; i < BAND_ROWS + 2; i++) win[i] = grid[win_row(pos, i)];
   end

   for (genvar r = 0; r < BAND_ROWS; r++) begin : g_row
      for (genvar c = 0; c < COLS; c++) begin : g_col
         localparam int CL = (c + COLS - 1) % COLS;
         localparam int CR = (c + 1) % COLS;
         life_cell_next u_cell (
            .nbr({win[r][CL], win[r][c], win[r][CR],
                  win[r+1][CL], win[r+1][CR],
                  win[r+2][CL], win[r+2][c], win[r+2][CR]}),
            .cur(win[r+1][c]),
            .nxt(nxt[r][c])
         );
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid       <= '0;
         shadow     <= '0;
         band_done  <= '0;
         wr_ack     <= 1'b0;
         rd_data    <= '0;
         mem_we     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         generation <= '0;
         gen_tick   <= 1'b0;
      end else begin
         wr_ack   <= 1'b0;
         mem_we   <= 1'b0;
         gen_tick <= 1'b0;
         rd_data  <= grid[rd_row];
         if (phase == PH_WRITE_ARRAY && wr_req) begin
            grid[wr_row] <= wr_data;
            band_done    <= '0;
            wr_ack       <= 1'b1;
         end else if (phase == PH_RUN) begin
            shadow[base +: BAND_ROWS] <= nxt;
            band_done[pos]            <= 1'b1;
         end else if (phase == PH_WRITE_MEM) begin
            mem_we    <= 1'b1;
            mem_addr  <= pos;
            mem_wdata <= grid[base +: BAND_ROWS];
            if (pos == 2'd3 && &band_done) begin
               grid       <= shadow;
               band_done  <= '0;
               generation <= generation + 16'd1;
               gen_tick   <= 1'b1;
            end
         end
      end
   end
endmodule

// File: doc/life_grid.md
Name: life_grid

Overview:
- Cell-array stage directly downstream of the phase controller.
- Consumes the controller's write_array / run / pos / write_mem strobes.
- Holds the current Game of Life generation as a COLS x ROWS toroidal register grid and computes the next generation one 4-row band per run slot into a shadow buffer.
- Commits a full generation atomically, and streams bands to frame memory on write_mem.

Parameters:
- COLS, 16, grid width in cells. Must be at least 3.
- ROWS, 16, grid height in cells. Must be 4 x BAND_ROWS. Band b holds rows b*BAND_ROWS .. b*BAND_ROWS+BAND_ROWS-1.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- write_array  in  1  controller phase strobe: host-write slot.
- run  in  1  controller phase strobe: compute slot for band pos.
- pos  in  2  band index of the current slot.
- write_mem  in  1  controller phase strobe: memory-write slot.
- wr_req  in  1  host row-write request; held until wr_ack.
- wr_row  in  clog2(ROWS)  row to overwrite.
- wr_data  in  COLS  new row contents; bit c = column c.
- wr_ack  out  1  one-cycle acknowledge of a host write.
- rd_row  in  clog2(ROWS)  display read address.
- rd_data  out  COLS  registered contents of rd_row.
- mem_we  out  1  frame-memory write enable.
- mem_addr  out  2  band index being written.
- mem_wdata  out  BAND_ROWS*COLS  band contents; lowest row in the LSBs.
- generation  out  16  committed generation count; wraps at 65535 -> 0.
- gen_tick  out  1  one-cycle pulse per commit.

Behaviour:
- Reset: while reset is low, independent of clk:
  - grid, shadow and band_done[3:0] are 0.
  - wr_ack, rd_data, mem_we, mem_addr, mem_wdata, generation and gen_tick are 0.
- Strobes: at most one is legal per cycle. If several are asserted, priority is write_array > run > write_mem; lower-priority strobes are ignored.
- Rule: B3/S23.
  - Neighbour count is 4-bit unsigned, range 0..8.
  - Next = (count == 3) | (cur & count == 2).
  - Toroidal wrap: row -1 -> ROWS-1, row ROWS -> 0; same for columns.
- write_array with wr_req=1:
  - Grid row wr_row <= wr_data at that edge.
  - band_done <= 0, because the shadow is now stale.
  - wr_ack = 1 for exactly the next cycle.
  - If wr_req is still high at a later write_array, the write repeats; dropping wr_req is the host's job.
- write_array with wr_req=0: no effect.
- run:
  - Shadow band pos <= next-state of the grid rows in band pos, computed from the current grid.
  - band_done[pos] <= 1.
  - Re-running a band already marked done recomputes the same value.
- write_mem:
  - mem_we = 1 for one cycle after the strobe edge.
  - mem_addr = pos.
  - mem_wdata = grid band pos as sampled at that edge, before any commit.
  - Otherwise mem_we = 0; mem_addr and mem_wdata hold their last values.
- Commit: at write_mem with pos == 3 and band_done == 4'b1111:
  - grid <= shadow.
  - band_done <= 0.
  - generation <= generation + 1.
  - gen_tick = 1 on the next cycle.
- Partial run window (some band_done bits still 0 at pos 3 write_mem): no commit. Bits persist until completed or cleared by a host write.
- rd_data <= grid[rd_row] every cycle; latency 1; reflects the post-commit grid one cycle after the commit edge.
- Reset mid-operation: the partial shadow is discarded; there is no pending ack or tick.

Decomposition:
- Package life_pkg:
  - BAND_ROWS = 4.
  - Phase encoding constants: 01 write_array, 10 run, 11 write_mem.
  - Rule constants BIRTH_COUNT = 3, SURVIVE_COUNT = 2.
- Sub-module life_cell_next: combinational; 8 neighbour bits + current bit -> next bit. Instantiated BAND_ROWS*COLS times, fed by a pos-selected band window with the wrapped rows above and below.

Test Plan:
- Reset: drive reset=0 mid-stream with no clk edge -> all outputs 0 immediately; generation = 0; rd_data = 0.
- Blinker:
  - Stimulus: host-write rows 7, 8, 9 = 16'h0020; issue one aligned run burst (pos 0..3) then write_mem pos 3.
  - Response: row 8 = 16'h0070; rows 7 and 9 = 0; generation = 1; exactly one gen_tick.
  - A second generation restores the column.
- Wrap:
  - Stimulus: 2x2 block on cells (0,0), (0,15), (15,0), (15,15); run one generation.
  - Response: grid unchanged; row 0 = row 15 = 16'h8001; generation = 1.
- Partial run and invalidation:
  - Stimulus: run only pos 0 and 1, then write_mem pos 3.
  - Response: no commit, generation unchanged.
  - Stimulus: host write, then run pos 2 and 3 only.
  - Response: still no commit. A full 4-band run then commits.
- Memory stream: grid rows 8..11 = 16'h0001, 16'h0002, 16'h0004, 16'h0008; write_mem with pos=2 -> next cycle mem_we=1, mem_addr=2, mem_wdata = 64'h0008_0004_0002_0001.
- Handshake: wr_req held across 3 non-write_array cycles -> no write and no ack. At the write_array edge -> row updated; wr_ack high for exactly 1 cycle.
